// File: rtl/nrzi_rx_deserializer.sv
// nrzi_rx_deserializer
// Receive-side NRZI line decoder. A line level equal to the previous one
// decodes as 1 and a transition decodes as 0. Decoded bits are assembled
// LSB-first into DATA_W-bit words, which are offered on a registered
// valid/ready port.
// Optional feature: define NRZI_RX_STUFF_EN to remove stuffed 0 bits after
// STUFF_LEN consecutive 1s and to flag stuffing violations on stuff_err.
// Without the macro every decoded bit is data and stuff_err is held at 0.
module nrzi_rx_deserializer #(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              line_in,
  input  logic              sync_clr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              stuff_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // Reject parameter values the word and run counters cannot represent.
  if (DATA_W < 2 || STUFF_LEN < 1) begin : g_bad_param
    $error("nrzi_rx_deserializer: DATA_W must be >= 2 and STUFF_LEN >= 1");
  end

  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t        out_state;
  logic              prev_line;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  logic              bit_dec;
  logic              take;
  logic              word_done;
  logic [DATA_W-1:0] shift_word;

`ifdef NRZI_RX_STUFF_EN
  localparam int ONES_W = $clog2(STUFF_LEN + 1);

  typedef enum logic {RECV, STUFF} rx_state_t;

  rx_state_t         rx_state;
  logic [ONES_W-1:0] ones_cnt;
`else
  assign stuff_err = 1'b0;
`endif

  // Decode the current line sample and decide whether it completes a word.
  // NOTE: every signal gets a value before any condition is evaluated, so
  // no path through this block can leave a variable holding its old value
  // and no latch is inferred.
  always_comb begin
    bit_dec    = (line_in == prev_line);
    shift_word = {bit_dec, shreg[DATA_W-1:1]};
`ifdef NRZI_RX_STUFF_EN
    take       = bit_en && !sync_clr && (rx_state == RECV);
`else
    take       = bit_en && !sync_clr;
`endif
    word_done  = take && (bit_cnt == CNT_W'(DATA_W - 1));
  end

  // Decoder: line history, shift register, bit/run counters and stuffing FSM.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values no matter how statements are ordered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_line <= 1'b1;
      // NOTE: the shift register is cleared on reset even though a full word
      // overwrites it, so a partial word never leaks into simulation as X.
      shreg     <= '0;
      bit_cnt   <= '0;
`ifdef NRZI_RX_STUFF_EN
      ones_cnt  <= '0;
      rx_state  <= RECV;
      stuff_err <= 1'b0;
`endif
    end else begin
`ifdef NRZI_RX_STUFF_EN
      stuff_err <= 1'b0;
`endif
      if (sync_clr) begin
        // Resync wins over a simultaneous strobe; that line sample is dropped.
        prev_line <= 1'b1;
        shreg     <= '0;
        bit_cnt   <= '0;
`ifdef NRZI_RX_STUFF_EN
        ones_cnt  <= '0;
        rx_state  <= RECV;
`endif
      end else if (bit_en) begin
        prev_line <= line_in;
`ifdef NRZI_RX_STUFF_EN
        if (rx_state == STUFF) begin
          // The bit after a full run of 1s must be a stuffed 0; a 1 here
          // means the link lost framing, so the partial word is abandoned.
          rx_state <= RECV;
          ones_cnt <= '0;
          if (bit_dec) begin
            stuff_err <= 1'b1;
            shreg     <= '0;
            bit_cnt   <= '0;
          end
        end else begin
          shreg   <= shift_word;
          bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
          // The run count deliberately survives word completion.
          if (bit_dec) begin
            ones_cnt <= ones_cnt + ONES_W'(1);
            if (ones_cnt == ONES_W'(STUFF_LEN - 1)) begin
              rx_state <= STUFF;
            end
          end else begin
            ones_cnt <= '0;
          end
        end
`else
        shreg   <= shift_word;
        bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
`endif
      end
    end
  end

  // Output holding register: EMPTY/FULL handshake plus sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_state <= EMPTY;
      overrun   <= 1'b0;
    end else begin
      // A completion never coincides with sync_clr, so this clear cannot
      // collide with the overrun set below.
      if (sync_clr) begin
        overrun <= 1'b0;
      end
      case (out_state)
        EMPTY: begin
          if (word_done) begin
            out_data  <= shift_word;
            out_state <= FULL;
          end
        end
        FULL: begin
          if (word_done) begin
            // Same-cycle accept frees the slot for the new word; otherwise
            // the pending word is kept and the new one is lost.
            if (out_ready) begin
              out_data <= shift_word;
            end else begin
              overrun <= 1'b1;
            end
          end else if (out_ready) begin
            out_state <= EMPTY;
          end
        end
        default: out_state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (out_state == FULL);

endmodule

// File: tb/tb_nrzi_rx_deserializer.sv
// tb_nrzi_rx_deserializer
// Self-checking bench for nrzi_rx_deserializer. Words are turned into a
// decoded-bit stream (with stuffed 0s when NRZI_RX_STUFF_EN is defined),
// NRZI-encoded and driven on random strobes; a word-level scoreboard predicts
// out_data/out_valid/overrun/stuff_err every cycle.
module tb_nrzi_rx_deserializer;

  localparam int DATA_W    = 8;
  localparam int STUFF_LEN = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              bit_en;
  logic              line_in;
  logic              sync_clr;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              overrun;
  logic              stuff_err;

  always #5 clk = ~clk;

  nrzi_rx_deserializer #(
    .DATA_W   (DATA_W),
    .STUFF_LEN(STUFF_LEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en   (bit_en),
    .line_in  (line_in),
    .sync_clr (sync_clr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun),
    .stuff_err(stuff_err)
  );

  // One decoded bit on the line: its value, whether it is the last data bit
  // of a word (and which word), and whether it breaks the stuffing rule.
  typedef struct {
    logic              val;
    logic              done;
    logic              viol;
    logic [DATA_W-1:0] word;
  } sym_t;

  sym_t              sq[$];
  int                vectors     = 0;
  int                miscompares = 0;
  int                ones_run    = 0;
  logic              line_lvl    = 1'b1;
  logic [DATA_W-1:0] exp_data    = '0;
  logic              exp_valid   = 1'b0;
  logic              exp_overrun = 1'b0;
  logic              exp_serr    = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("out_data",  32'(out_data),  32'(exp_data));
    check("overrun",   32'(overrun),   32'(exp_overrun));
    check("stuff_err", 32'(stuff_err), 32'(exp_serr));
  endtask

  task automatic push_sym(input logic val, input logic done, input logic viol,
                          input logic [DATA_W-1:0] word);
    sym_t s;
    s.val  = val;
    s.done = done;
    s.viol = viol;
    s.word = word;
    sq.push_back(s);
  endtask

  // Queue a word LSB-first, inserting a stuffed 0 after every run of
  // STUFF_LEN data 1s; runs continue across word boundaries.
  task automatic push_word(input logic [DATA_W-1:0] w);
    for (int i = 0; i < DATA_W; i++) begin
      push_sym(w[i], (i == DATA_W - 1), 1'b0, w);
`ifdef NRZI_RX_STUFF_EN
      ones_run = w[i] ? ones_run + 1 : 0;
      if (ones_run == STUFF_LEN) begin
        push_sym(1'b0, 1'b0, 1'b0, '0);
        ones_run = 0;
      end
`endif
    end
  endtask

  // One clock: drive inputs, advance the scoreboard, compare after the edge.
  task automatic cycle(input logic en, input logic rdy, input logic clr);
    sym_t              s;
    logic              take;
    logic              nv;
    logic              no;
    logic              nse;
    logic [DATA_W-1:0] nd;
    s    = '{val: 1'b0, done: 1'b0, viol: 1'b0, word: '0};
    take = en && !clr && (sq.size() > 0);
    if (take) begin
      s = sq.pop_front();
      if (!s.val) line_lvl = ~line_lvl;
      line_in = line_lvl;
    end else begin
      line_in = 1'($urandom_range(1));
    end
    bit_en    = clr ? en : take;
    sync_clr  = clr;
    out_ready = rdy;
    if (clr) begin
      sq.delete();
      ones_run = 0;
      line_lvl = 1'b1;
    end
    nv  = exp_valid;
    nd  = exp_data;
    no  = exp_overrun && !clr;
    nse = take && s.viol;
    if (take && s.done) begin
      if (!exp_valid || rdy) begin
        nd = s.word;
        nv = 1'b1;
      end else begin
        no = 1'b1;
      end
    end else if (exp_valid && rdy) begin
      nv = 1'b0;
    end
    @(posedge clk);
    exp_valid   = nv;
    exp_data    = nd;
    exp_overrun = no;
    exp_serr    = nse;
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic run(input logic rdy);
    while (sq.size() > 0) cycle(1'b1, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bit_en    = 1'b1;
    line_in   = 1'($urandom_range(1));
    sync_clr  = 1'b0;
    out_ready = 1'b0;
    sq.delete();
    ones_run  = 0;
    line_lvl  = 1'b1;
    @(posedge clk);
    exp_valid   = 1'b0;
    exp_data    = '0;
    exp_overrun = 1'b0;
    exp_serr    = 1'b0;
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    bit_en    = 1'b0;
    line_in   = 1'b1;
    sync_clr  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Basic word: levels 1,0,0,1,0,0,1,1 decode to 0xA5, accepted at once.
    push_word(8'hA5);
    run(1'b1);
    cycle(1'b0, 1'b1, 1'b0);

    // All ones: stuffed 0 removed when stuffing is on, plain 8 bits otherwise.
    do_reset();
    push_word(8'hFF);
    run(1'b0);
    cycle(1'b0, 1'b1, 1'b0);

`ifdef NRZI_RX_STUFF_EN
    // Seven decoded 1s from a fresh word: error pulse, no word, then recovery.
    do_reset();
    for (int i = 0; i < STUFF_LEN; i++) push_sym(1'b1, 1'b0, 1'b0, '0);
    push_sym(1'b1, 1'b0, 1'b1, '0);
    run(1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    push_word(8'hA5);
    run(1'b0);
    cycle(1'b0, 1'b1, 1'b0);
`endif

    // Overrun: second word dropped, sync_clr clears the flag but keeps the word.
    do_reset();
    push_word(8'h3C);
    push_word(8'hC3);
    run(1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    // Ready in the completion cycle of the next word.
    do_reset();
    push_word(8'h11);
    run(1'b0);
    push_word(8'h22);
    while (sq.size() > 1) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    // Reset mid-word while a word is pending, then a clean 0x5A.
    do_reset();
    push_word(8'h99);
    run(1'b0);
    push_word(8'h5A);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    push_word(8'h5A);
    run(1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    // Resync mid-word with a simultaneous strobe, then 0x5A.
    push_word(8'h5A);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    push_word(8'h5A);
    run(1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    // Random words, strobe gaps, back-pressure and occasional resyncs.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (sq.size() < DATA_W) push_word(DATA_W'($urandom));
      cycle(($urandom_range(3) != 0), 1'($urandom_range(1)), ($urandom_range(99) == 0));
    end
    // Long back-to-back run with the consumer always ready.
    for (int c = 0; c < 500; c++) begin
      if (sq.size() < DATA_W) push_word(DATA_W'($urandom));
      cycle(1'b1, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
